// File: rtl/cond_status_unit_pkg.sv
// rtl/cond_status_unit_pkg.sv - shared processor constants for condition evaluation
`timescale 1ns/1ps
package cond_status_unit_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/cond_status_unit_cond_decode.sv
// rtl/cond_status_unit_cond_decode.sv - combinational condition-code decode
`timescale 1ns/1ps
module cond_decode
    import cond_status_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       true
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        true = 1'b0;
        case (cond)
            COND_EQ: true = z;
            COND_NE: true = !z;
            COND_CS: true = c;
            COND_CC: true = !c;
            COND_MI: true = n;
            COND_PL: true = !n;
            COND_VS: true = v;
            COND_VC: true = !v;
            COND_HI: true = c && !z;
            COND_LS: true = !c || z;
            COND_GE: true = (n == v);
            COND_LT: true = (n != v);
            COND_GT: true = !z && (n == v);
            COND_LE: true = z || (n != v);
            COND_AL: true = 1'b1;
            COND_NV: true = 1'b0;
            default: true = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_status_unit.sv
// rtl/cond_status_unit.sv - flag register, bypass mux and registered condition result
`timescale 1ns/1ps
module cond_status_unit
    import cond_status_unit_pkg::*;
#(
    parameter bit BYPASS = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nout,
    input  logic       zout,
    input  logic       cout,
    input  logic       vout,
    input  logic       s_en,
    input  logic       psr_ld,
    input  logic [3:0] psr_data,
    input  logic       eval_req,
    input  logic [3:0] cond,
    input  logic       stall,
    output logic       nin,
    output logic       zin,
    output logic       cin,
    output logic       vin,
    output logic [3:0] flags,
    output logic       cond_valid,
    output logic       cond_true
);

    logic [3:0] flag_q;
    logic [3:0] flag_d;
    logic [3:0] eval_flags;
    logic       flag_upd;
    logic       dec_true;
    logic       valid_q;
    logic       true_q;

    // A direct PSR load wins over the ALU flag update in the same cycle.
    always_comb begin
        flag_d   = flag_q;
        flag_upd = 1'b0;
        if (!stall) begin
            if (psr_ld) begin
                flag_d   = psr_data;
                flag_upd = 1'b1;
            end else if (s_en) begin
                flag_d   = pack_flags(nout, zout, cout, vout);
                flag_upd = 1'b1;
            end
        end
    end

    assign eval_flags = (BYPASS && flag_upd) ? flag_d : flag_q;

    cond_decode u_cond_decode (
        .cond  (cond),
        .flags (eval_flags),
        .true  (dec_true)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q  <= 4'b0000;
            valid_q <= 1'b0;
            true_q  <= 1'b0;
        end else if (!stall) begin
            flag_q  <= flag_d;
            valid_q <= eval_req;
            if (eval_req) begin
                true_q <= dec_true;
            end
        end
    end

    assign flags      = flag_q;
    assign nin        = flag_q[FLAG_N];
    assign zin        = flag_q[FLAG_Z];
    assign cin        = flag_q[FLAG_C];
    assign vin        = flag_q[FLAG_V];
    assign cond_valid = valid_q;
    assign cond_true  = true_q;

endmodule

// File: tb/tb_cond_status_unit.sv
// tb/tb_cond_status_unit.sv - self-checking bench for cond_status_unit (BYPASS 0 and 1)
`timescale 1ns/1ps
module tb_cond_status_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       nout = 1'b0, zout = 1'b0, cout = 1'b0, vout = 1'b0;
    logic       s_en = 1'b0;
    logic       psr_ld = 1'b0;
    logic [3:0] psr_data = 4'b0000;
    logic       eval_req = 1'b0;
    logic [3:0] cond = 4'b0000;
    logic       stall = 1'b0;

    logic       n0, z0, c0, v0, valid0, true0;
    logic [3:0] flags0;
    logic       n1, z1, c1, v1, valid1, true1;
    logic [3:0] flags1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] m_flags = 4'b0000;
    logic       m_valid = 1'b0;
    logic       m_true0 = 1'b0;
    logic       m_true1 = 1'b0;

    always #5 clk = ~clk;

    cond_status_unit #(.BYPASS(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .nout(nout), .zout(zout), .cout(cout), .vout(vout),
        .s_en(s_en), .psr_ld(psr_ld), .psr_data(psr_data),
        .eval_req(eval_req), .cond(cond), .stall(stall),
        .nin(n0), .zin(z0), .cin(c0), .vin(v0),
        .flags(flags0), .cond_valid(valid0), .cond_true(true0)
    );

    cond_status_unit #(.BYPASS(1'b1)) dut1 (
        .clk(clk), .reset(reset),
        .nout(nout), .zout(zout), .cout(cout), .vout(vout),
        .s_en(s_en), .psr_ld(psr_ld), .psr_data(psr_data),
        .eval_req(eval_req), .cond(cond), .stall(stall),
        .nin(n1), .zin(z1), .cin(c1), .vin(v1),
        .flags(flags1), .cond_valid(valid1), .cond_true(true1)
    );

    // Conditions come in complementary pairs: cond[3:1] picks the test, cond[0] inverts it.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic [2:0] sel;
        logic n, z, cc, v, base;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        sel = c[3:1];
        case (sel)
            3'd0:    base = z;
            3'd1:    base = cc;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cc & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? ~base : base;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [3:0] nxt;
        logic [3:0] e1;
        logic       upd;
        nxt = m_flags;
        upd = 1'b0;
        if (!stall) begin
            if (psr_ld) begin
                nxt = psr_data; upd = 1'b1;
            end else if (s_en) begin
                nxt = {nout, zout, cout, vout}; upd = 1'b1;
            end
            e1 = upd ? nxt : m_flags;
            if (eval_req) begin
                m_true0 = ref_cond(cond, m_flags);
                m_true1 = ref_cond(cond, e1);
            end
            m_valid = eval_req;
            m_flags = nxt;
        end
        @(posedge clk);
        #1;
        chk("flags0", flags0, m_flags);
        chk("flags1", flags1, m_flags);
        chk("fb0", {n0, z0, c0, v0}, m_flags);
        chk("fb1", {n1, z1, c1, v1}, m_flags);
        chk("valid0", {3'b000, valid0}, {3'b000, m_valid});
        chk("valid1", {3'b000, valid1}, {3'b000, m_valid});
        chk("true0", {3'b000, true0}, {3'b000, m_true0});
        chk("true1", {3'b000, true1}, {3'b000, m_true1});
    endtask

    task automatic idle();
        s_en = 1'b0; psr_ld = 1'b0; eval_req = 1'b0; stall = 1'b0;
        nout = 1'b0; zout = 1'b0; cout = 1'b0; vout = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_seq;
        exp_seq = 4'b1010;

        // Reset state while reset is held across an edge
        @(posedge clk);
        #1;
        chk("rst_flags0", flags0, 4'b0000);
        chk("rst_fb1", {n1, z1, c1, v1}, 4'b0000);
        chk("rst_valid0", {3'b000, valid0}, 4'b0000);
        chk("rst_true1", {3'b000, true1}, 4'b0000);
        #2 reset = 1'b0;

        // Load 0100 then evaluate EQ
        psr_ld = 1'b1; psr_data = 4'b0100;
        cycle();
        chk("ld0100", flags0, 4'b0100);
        idle(); eval_req = 1'b1; cond = 4'b0000;
        cycle();
        chk("eq_valid", {3'b000, valid0}, 4'b0001);
        chk("eq_true", {3'b000, true0}, 4'b0001);
        idle();

        // Back-to-back GE, LT, GT, NV on flags 1001
        psr_ld = 1'b1; psr_data = 4'b1001;
        cycle();
        idle();
        for (int i = 0; i < 4; i++) begin
            eval_req = 1'b1;
            case (i)
                0: cond = 4'b1010;
                1: cond = 4'b1011;
                2: cond = 4'b1100;
                default: cond = 4'b1111;
            endcase
            cycle();
            chk("b2b_valid", {3'b000, valid0}, 4'b0001);
            chk("b2b_true", {3'b000, true0}, {3'b000, exp_seq[3 - i]});
        end
        idle();

        // Same-cycle update and evaluation: stored vs bypassed flags
        psr_ld = 1'b1; psr_data = 4'b0000;
        cycle();
        idle(); s_en = 1'b1; zout = 1'b1; eval_req = 1'b1; cond = 4'b0000;
        cycle();
        chk("byp0_true", {3'b000, true0}, 4'b0000);
        chk("byp1_true", {3'b000, true1}, 4'b0001);
        chk("byp_flags", flags0, 4'b0100);
        idle();

        // psr_ld has priority over s_en
        psr_ld = 1'b1; psr_data = 4'b0010; s_en = 1'b1; nout = 1'b1;
        cycle();
        chk("prio_flags", flags0, 4'b0010);
        idle();

        // Stall holds everything
        psr_ld = 1'b1; psr_data = 4'b0101;
        cycle();
        idle(); eval_req = 1'b1; cond = 4'b0000;
        cycle();
        stall = 1'b1; eval_req = 1'b1; cond = 4'b1111; s_en = 1'b1;
        nout = 1'b1; cout = 1'b1; psr_ld = 1'b1; psr_data = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_flags", flags0, 4'b0101);
            chk("stall_valid", {3'b000, valid1}, 4'b0001);
            chk("stall_true", {3'b000, true1}, 4'b0001);
        end
        idle();

        // Asynchronous reset with a result pending
        eval_req = 1'b1; cond = 4'b1110;
        cycle();
        #2 reset = 1'b1;
        #1;
        chk("arst_valid0", {3'b000, valid0}, 4'b0000);
        chk("arst_valid1", {3'b000, valid1}, 4'b0000);
        chk("arst_flags0", flags0, 4'b0000);
        chk("arst_flags1", flags1, 4'b0000);
        m_flags = 4'b0000; m_valid = 1'b0; m_true0 = 1'b0; m_true1 = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        idle();

        // First edge after reset is accepted normally
        psr_ld = 1'b1; psr_data = 4'b1100; eval_req = 1'b1; cond = 4'b1110;
        cycle();
        chk("post_rst_flags", flags0, 4'b1100);
        chk("post_rst_valid", {3'b000, valid0}, 4'b0001);
        idle();

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            stall    = ($urandom % 5) == 0;
            psr_ld   = ($urandom % 4) == 0;
            s_en     = ($urandom % 2) == 0;
            eval_req = ($urandom % 4) != 0;
            cond     = 4'($urandom);
            psr_data = 4'($urandom);
            {nout, zout, cout, vout} = 4'($urandom);
            cycle();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cond_status_unit.md
COND_STATUS_UNIT -- requirements
Module: cond_status_unit

Interface
REQ-001 Parameter BYPASS, default 0: when 1, an evaluation in the same cycle as a flag update uses the incoming flags; when 0, it uses the stored flags.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 nout, zout, cout, vout  input  1 each  flag results from the ALU.
REQ-005 s_en  input  1  update the stored flags from nout/zout/cout/vout.
REQ-006 psr_ld  input  1  direct load of the stored flags from psr_data.
REQ-007 psr_data  input  4  direct-load value, ordered {N,Z,C,V}.
REQ-008 eval_req  input  1  condition-evaluation request, qualified by stall.
REQ-009 cond  input  4  condition field to evaluate.
REQ-010 stall  input  1  freezes all state.
REQ-011 nin, zin, cin, vin  output  1 each  stored flags, fed back to the ALU flag inputs.
REQ-012 flags  output  4  stored flags {N,Z,C,V}.
REQ-013 cond_valid  output  1  cond_true is valid this cycle.
REQ-014 cond_true  output  1  registered result of the condition evaluation.

Function
REQ-015 nin/zin/cin/vin and flags shall be driven directly from the 4-bit flag register, with no combinational path from inputs.
REQ-016 When stall=0, psr_ld=1: the flag register loads psr_data on the next edge; s_en is ignored that cycle.
REQ-017 When stall=0, psr_ld=0, s_en=1: the flag register loads {nout,zout,cout,vout} on the next edge.
REQ-018 Otherwise the flag register holds its value.
REQ-019 Condition mapping (F = evaluated flags):
- 0000 EQ: Z
- 0001 NE: !Z
- 0010 CS: C
- 0011 CC: !C
- 0100 MI: N
- 0101 PL: !N
- 0110 VS: V
- 0111 VC: !V
- 1000 HI: C & !Z
- 1001 LS: !C | Z
- 1010 GE: N==V
- 1011 LT: N!=V
- 1100 GT: !Z & (N==V)
- 1101 LE: Z | (N!=V)
- 1110 AL: 1
- 1111 NV: 0
REQ-020 Latency: eval_req=1 with stall=0 in cycle t gives cond_valid=1 and cond_true in cycle t+1 (one register stage).
REQ-021 cond_valid shall be 0 in the cycle after eval_req=0 with stall=0, and cond_true shall then hold its last value.
REQ-022 Evaluated flags for BYPASS=0: the flag register contents at cycle t, i.e. before any same-cycle update.
REQ-023 Evaluated flags for BYPASS=1, same-cycle update: the value being loaded, with psr_data taking priority over the ALU flags.
REQ-024 Evaluated flags for BYPASS=1, no update: the flag register contents.
REQ-025 When stall=1, the flag register, cond_valid and cond_true shall all hold, and eval_req, s_en and psr_ld shall be ignored.
REQ-026 Back-to-back eval_req in consecutive cycles shall produce one result per cycle, with no bubbles.
REQ-027 The result for each eval_req shall be computed from that request's own cond.

Reset
REQ-028 While reset=1: flags=4'b0000, nin=zin=cin=vin=0, cond_valid=0, cond_true=0.
REQ-029 Reset shall take effect asynchronously and discard any evaluation in flight.
REQ-030 In the first edge after reset deasserts, the block shall accept eval_req, s_en and psr_ld normally.

Structure
REQ-031 The following shall live in the shared processor package:
- 4-bit condition-code constants (EQ..NV)
- flag bit-index constants (N=3, Z=2, C=1, V=0)
REQ-032 Condition decode shall be a combinational sub-module cond_decode (inputs cond and flags, output true), instantiated once.
REQ-033 The top level holds only the flag register, the bypass mux and the result register.

Verification
REQ-034 Reset, then psr_ld=1 with psr_data=4'b0100 -> next cycle flags=0100; then eval_req=1 with cond=0000 -> one cycle later cond_valid=1, cond_true=1.
REQ-035 Flags 1001 (N=1, V=1): cond=1010 GE -> 1; cond=1011 LT -> 0; cond=1100 GT -> 1; cond=1111 NV -> 0; issued back-to-back, giving four consecutive valid results.
REQ-036 BYPASS=0, flags=0000, same cycle s_en=1 with zout=1 and eval_req=1 with cond=0000 -> cond_true=0, and flags=0100 afterwards; with BYPASS=1 the same stimulus -> cond_true=1.
REQ-037 psr_ld=1 with psr_data=0010 and s_en=1 with {nout,zout,cout,vout}=1000 in the same cycle -> flags=0010.
REQ-038 stall=1 for 3 cycles with eval_req=1 and s_en=1 -> flags, cond_valid and cond_true unchanged throughout.
REQ-039 Assert reset mid-evaluation (eval_req accepted, result pending) -> cond_valid=0 and flags=0000 immediately, without waiting for a clock edge.
